// File: rtl/pipe_fetch_queue_if.sv
// Fetch stage bundle: PC-unit handshake, instruction memory req/ack, decode valid/stall.
interface pipe_fetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_4;
    logic        id_exc;

    modport slave (
        input  pc_in, pc_valid, flush, imem_ack, imem_rdata, id_stall,
        output pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4, id_exc
    );

    modport master (
        output pc_in, pc_valid, flush, imem_ack, imem_rdata, id_stall,
        input  pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4, id_exc
    );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Fetch stage: one outstanding imem req/ack, {pc, instr} FIFO toward decode, flush on redirect.
// Optional macro FETCH_ALIGN_CHECK_EN turns misaligned fetches into exception entries.
module pipe_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic clk,
    input logic rst,
    pipe_fetch_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } entry_t;

    // Bit 0 doubles as imem_req so the request comes straight off a flop.
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DROP = 2'b11} state_t;

    state_t          state, state_nxt;
    entry_t          mem [DEPTH];
    entry_t          head, last_q, push_data;
    logic [31:0]     addr_q, last_pc4_q, head_pc4;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            accept, misalign, push, pop, nonempty;
    logic            unused_exc;

    assign accept   = bus.pc_valid && bus.pc_ready;
    assign nonempty = (count != '0);
    assign pop      = nonempty && !bus.id_stall;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (bus.pc_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !misalign) state_nxt = WAIT;
            WAIT:    if (bus.imem_ack) state_nxt = IDLE;
                     else if (bus.flush) state_nxt = DROP;
            DROP:    if (bus.imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pc_ready = (state == IDLE) && (count < CW'(DEPTH)) && !bus.flush && !rst;
        push         = 1'b0;
        push_data    = '{pc: addr_q, instr: bus.imem_rdata, exc: 1'b0};
        case (state)
            IDLE: if (accept && misalign) begin
                push      = 1'b1;
                push_data = '{pc: bus.pc_in, instr: 32'h0, exc: 1'b1};
            end
            WAIT:    push = bus.imem_ack && !bus.flush;
            default: push = 1'b0;
        endcase
    end

    assign bus.imem_req  = state[0];
    assign bus.imem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       addr_q <= RESET_PC;
        else if (accept && !misalign)  addr_q <= {bus.pc_in[31:2], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem[wr_ptr] <= push_data;
    end

    // Shadow of the last head shown, so id_* hold once the queue drains or flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_pc4_q <= '0;
        end else if (nonempty) begin
            last_q     <= mem[rd_ptr];
            last_pc4_q <= head_pc4;
        end
    end

    assign head         = nonempty ? mem[rd_ptr] : last_q;
    assign head_pc4     = mem[rd_ptr].pc + 32'd4;
    assign bus.id_valid = nonempty;
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;
    assign bus.id_pc_4  = nonempty ? head_pc4 : last_pc4_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.id_exc = head.exc;
    assign unused_exc = 1'b0;
`else
    assign bus.id_exc = 1'b0;
    assign unused_exc = head.exc;
`endif
endmodule
